// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch: byte-addressed instruction memory for the fetch stage.
// After reset the array is zeroed one word per cycle (CLEAR), then it can be
// loaded byte-by-byte (LOAD) and serves big-endian word fetches with a
// registered response (IDLE).
// Optional macro FETCH_WAIT_EN: adds WAIT_CYCLES of response latency through a
// WAIT state and disables back-to-back overlap of fetches.
//
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers on an edge where rsp_valid && rsp_ready. While
// rsp_valid is high and rsp_ready is low, rsp_instr and rsp_err hold steady.
module inst_mem_fetch #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_BYTES = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int BPW   = DATA_W / 8;
    localparam int WORDS = DEPTH_BYTES / BPW;
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_LOAD  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PTR_W-1:0]    r_clr_ptr;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [7:0]          r_mem [DEPTH_BYTES];
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_instr;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_misalign;
    logic [ADDR_W:0]     w_end;
    logic                w_oob;
    logic                w_err;
    logic [IDX_W-1:0]    w_rd_base;
    logic [IDX_W-1:0]    w_clr_base;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_load_hit;
    logic                w_wait_done;

    assign rsp_valid = r_rsp_valid;
    assign rsp_instr = r_rsp_instr;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

    assign w_accept   = req_valid && req_ready;
    // End address is formed one bit wider so addresses near the top cannot wrap.
    assign w_misalign = (req_addr % ADDR_W'(BPW)) != '0;
    assign w_end      = {1'b0, req_addr} + (ADDR_W+1)'(BPW);
    assign w_oob      = w_end > (ADDR_W+1)'(DEPTH_BYTES);
    assign w_err      = w_misalign || w_oob;
    assign w_rd_base  = req_addr[IDX_W-1:0];
    assign w_clr_base = IDX_W'(r_clr_ptr) * IDX_W'(BPW);
    assign w_load_hit = {1'b0, load_addr} < (ADDR_W+1)'(DEPTH_BYTES);
    assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(1));

    // Next-state, request-ready and busy decode.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_CLEAR: begin
                busy = 1'b1;
                if (r_clr_ptr == PTR_W'(WORDS - 1)) w_next = S_IDLE;
            end
            S_IDLE: begin
                busy = 1'b0;
`ifdef FETCH_WAIT_EN
                req_ready = !load_en && !r_rsp_valid;
`else
                req_ready = !load_en && (!r_rsp_valid || rsp_ready);
`endif
                if (load_en && !r_rsp_valid) begin
                    w_next = S_LOAD;
                end
`ifdef FETCH_WAIT_EN
                else if (req_valid && req_ready && (WAIT_CYCLES != 0)) begin
                    w_next = S_WAIT;
                end
`endif
            end
            S_LOAD: begin
                busy = 1'b1;
                if (!load_en) w_next = S_IDLE;
            end
            S_WAIT: begin
                busy = 1'b0;
                if (r_wait_cnt == CNT_W'(1)) w_next = S_IDLE;
            end
            default: begin
                w_next = S_CLEAR;
            end
        endcase
    end

    // State register; reset restarts the clear sweep.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_CLEAR;
        else       r_state <= w_next;
    end

    // Clear pointer walks one word per CLEAR cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_ptr <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_ptr == PTR_W'(WORDS - 1)) r_clr_ptr <= '0;
            else                                r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // Latency counter: loaded on accept, counted down only while in WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= CNT_W'(WAIT_CYCLES);
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Memory array writes: whole-word zeroing in CLEAR, single bytes in LOAD.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                for (int b = 0; b < BPW; b++) begin
                    r_mem[w_clr_base + IDX_W'(b)] <= 8'h00;
                end
            end else if ((r_state == S_LOAD) && load_we && w_load_hit) begin
                r_mem[load_addr[IDX_W-1:0]] <= load_data;
            end
        end
    end

    // Big-endian word assembly: lowest address lands in the top byte.
    always_comb begin
        w_rd_word = '0;
        for (int b = 0; b < BPW; b++) begin
            w_rd_word[DATA_W-1-8*b -: 8] = r_mem[w_rd_base + IDX_W'(b)];
        end
    end

    // Response register: data captured on accept, valid follows the handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rsp_instr <= w_err ? '0 : w_rd_word;
                r_rsp_err   <= w_err;
            end
`ifdef FETCH_WAIT_EN
            if (w_accept && (WAIT_CYCLES == 0)) begin
                r_rsp_valid <= 1'b1;
            end else if (w_wait_done) begin
                r_rsp_valid <= 1'b1;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
`else
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// tb_inst_mem_fetch: randomized and directed bench for inst_mem_fetch with a
// byte-array reference model and an expected-response queue.
module tb_inst_mem_fetch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int BPW    = DATA_W / 8;
    localparam int WAITC  = 2;
`ifdef FETCH_WAIT_EN
    localparam int EXP_LAT = 1 + WAITC;
`else
    localparam int EXP_LAT = 1;
`endif

    logic              clock;
    logic              reset;
    logic              load_en;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_err;
    logic              busy;
    logic [1:0]        dbg_state;

    inst_mem_fetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC)
    ) dut (
        .clock(clock), .reset(reset),
        .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]        model_mem [DEPTH];
    logic [DATA_W:0]   exp_q [$];
    int                pop_cyc_q [$];
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W:0]   mon_exp;
    logic [DATA_W-1:0] last_rsp_instr;
    logic              last_rsp_err;
    int                bp_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response word from the memory image: error on misalignment or overrun.
    function automatic logic [DATA_W:0] model_rsp(input logic [ADDR_W-1:0] a);
        longint unsigned ea;
        logic [DATA_W-1:0] w;
        logic err;
        ea  = 64'(a);
        w   = '0;
        err = ((ea % BPW) != 0) || ((ea + BPW) > DEPTH);
        if (!err) begin
            for (int b = 0; b < BPW; b++) w = {w[DATA_W-9:0], model_mem[int'(ea) + b]};
        end
        return {err, w};
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 6)      return ADDR_W'($urandom_range(0, DEPTH / BPW - 1)) * 4;
        else if (k == 7) return ADDR_W'($urandom_range(0, DEPTH - 1));
        else if (k == 8) return ADDR_W'(DEPTH) + ADDR_W'($urandom_range(0, 63)) * 4;
        else             return 32'hFFFF_FFFC + ADDR_W'($urandom_range(0, 3));
    endfunction

    // Monitor: every response handshake pops one expected entry.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got response 0x%0h with no expected entry", rsp_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_instr", 64'(rsp_instr), 64'(mon_exp[DATA_W-1:0]));
                check("rsp_err", 64'(rsp_err), 64'(mon_exp[DATA_W]));
            end
            last_rsp_instr = rsp_instr;
            last_rsp_err   = rsp_err;
            pop_cyc_q.push_back(cyc);
        end
    end

    // Consumer backpressure: 0 always ready, 1 stalled, 2 random.
    always @(posedge clock) begin
        #2;
        case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        load_en = 1'b0;
        load_we = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic check_clear_window();
        int n;
        @(negedge clock);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_rsp_instr", 64'(rsp_instr), 0);
        check("rst_rsp_err", 64'(rsp_err), 0);
        check("rst_req_ready", 64'(req_ready), 0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check("clear_busy_cycles", 64'(n), 64'(DEPTH / BPW));
        check("idle_busy", 64'(busy), 0);
        check("idle_req_ready", 64'(req_ready), 1);
        tick();
    endtask

    task automatic enter_load();
        int n;
        n = 0;
        load_en = 1'b1;
        do begin
            tick();
            n++;
        end while (busy !== 1'b1 && n < 50);
        check("enter_load_busy", 64'(busy), 1);
    endtask

    task automatic exit_load();
        load_en = 1'b0;
        tick();
        check("exit_load_busy", 64'(busy), 0);
    endtask

    task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        load_we = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_we = 1'b0;
        if (64'(a) < DEPTH) model_mem[int'(a)] = d;
    endtask

    // Present a request and hold it until the DUT accepts it.
    task automatic issue(input logic [ADDR_W-1:0] a, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        req_valid = 1'b1;
        req_addr = a;
        forever begin
            @(negedge clock);
            if (req_ready === 1'b1) begin
                exp_q.push_back(model_rsp(a));
                tick();
                acc_cyc = cyc;
                break;
            end
            tick();
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: addr 0x%0h never accepted", a);
                break;
            end
        end
    endtask

    task automatic wait_valid(output int lat, input int acc_cyc);
        int n;
        n = 0;
        lat = -1;
        forever begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                lat = cyc - acc_cyc + 1;
                break;
            end
            check("wait_req_ready", 64'(req_ready), 0);
            n++;
            if (n > 50) break;
        end
    endtask

    task automatic fetch_one(input logic [ADDR_W-1:0] a);
        int acc;
        int lat;
        issue(a, acc);
        req_valid = 1'b0;
        if (acc >= 0) begin
            wait_valid(lat, acc);
            check("latency", 64'(lat), 64'(EXP_LAT));
            tick();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        int lat;
        int base;
        reset = 1'b1;
        load_en = 1'b0;
        load_we = 1'b0;
        load_addr = '0;
        load_data = '0;
        req_valid = 1'b0;
        req_addr = '0;
        last_rsp_instr = '0;
        last_rsp_err = 1'b0;

        // Reset and clear window, then an all-zero fetch.
        do_reset(1);
        check_clear_window();
        fetch_one(0);
        drain();
        check("t1_instr", 64'(last_rsp_instr), 0);

        // Load a word and read it back big-endian.
        enter_load();
        load_byte(0, 8'h80);
        load_byte(1, 8'h01);
        load_byte(2, 8'h06);
        load_byte(3, 8'h0A);
        exit_load();
        fetch_one(0);
        drain();
        check("t2_instr", 64'(last_rsp_instr), 64'h8001060A);

        // Error boundaries.
        fetch_one(2);
        drain();
        check("t3_misalign_err", 64'(last_rsp_err), 1);
        fetch_one(508);
        drain();
        check("t3_top_word_err", 64'(last_rsp_err), 0);
        fetch_one(512);
        drain();
        check("t3_past_end_err", 64'(last_rsp_err), 1);
        fetch_one(32'hFFFF_FFFC);
        drain();
        check("t3_wrap_err", 64'(last_rsp_err), 1);
        check("t3_wrap_instr", 64'(last_rsp_instr), 0);

        // Response hold under backpressure, then a back-to-back stream.
        bp_mode = 1;
        issue(0, acc);
        wait_valid(lat, acc);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 64'(rsp_valid), 1);
            check("hold_instr", 64'(rsp_instr), 64'h8001060A);
            check("hold_req_ready", 64'(req_ready), 0);
            @(negedge clock);
        end
        tick();
        bp_mode = 0;
        base = pop_cyc_q.size();
        issue(0, acc);
        issue(4, acc);
        issue(8, acc);
        req_valid = 1'b0;
        drain();
        check("stream_pop_count", 64'(pop_cyc_q.size() - base), 4);
`ifndef FETCH_WAIT_EN
        check("stream_gap_1", 64'(pop_cyc_q[base + 2] - pop_cyc_q[base + 1]), 1);
        check("stream_gap_2", 64'(pop_cyc_q[base + 3] - pop_cyc_q[base + 2]), 1);
`endif

        // Load has priority over fetch; out-of-range writes are dropped.
        load_en = 1'b1;
        req_valid = 1'b1;
        req_addr = 12;
        @(negedge clock);
        check("prio_req_ready", 64'(req_ready), 0);
        tick();
        check("prio_busy", 64'(busy), 1);
        req_valid = 1'b0;
        load_byte(600, 8'hA5);
        exit_load();
        fetch_one(596);
        drain();
        check("t5_596_err", 64'(last_rsp_err), 1);
        fetch_one(88);
        drain();
        check("t5_alias_instr", 64'(last_rsp_instr), 0);

        // Reset in the middle of LOAD wipes pre-reset contents.
        enter_load();
        load_byte(4, 8'hFF);
        do_reset(1);
        check_clear_window();
        fetch_one(4);
        drain();
        check("t6_instr", 64'(last_rsp_instr), 0);
        fetch_one(0);
        drain();
        check("t6_word0", 64'(last_rsp_instr), 0);

        // Random loads followed by random fetches with random backpressure.
        enter_load();
        for (int i = 0; i < 80; i++) begin
            load_byte(ADDR_W'($urandom_range(0, 639)), 8'($urandom));
        end
        exit_load();
        bp_mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                tick();
            end
            issue(rand_addr(), acc);
        end
        req_valid = 1'b0;
        bp_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
